sram_rr_arbiter: RTL
====================

Name: sram_rr_arbiter

Overview:
- Shares the single downstream SRAM-style memory port (the port in front of the AXI bridge) between the cache and uncached requesters.
- Read requesters: icache refill, dcache refill, LSU uncached read.
- Write requesters: dcache writeback, LSU uncached write.
- Round-robin among reads; writes have priority over reads, bounded by a read-starvation limit.
- Exactly one downstream transaction is outstanding at any time.

Parameters:
N_RD, 3, number of read requesters (0 icache, 1 dcache, 2 uncached)
N_WR, 2, number of write requesters (0 dcache, 1 uncached)
ADDR_W, 32, address width
LINE_W, 256, data width of the read and write buses
TYPE_W, 6, transfer-type field width
STRB_W, 16, write strobe width
MAX_WAIT, 8, consecutive write grants allowed while any read is pending

Ports:
clock  in  1  single clock
reset  in  1  asynchronous, active-high reset
rd_req  in  N_RD  per-requester read request, held until rd_rdy
rd_addr  in  N_RD*ADDR_W  packed read addresses
rd_type  in  N_RD*TYPE_W  packed read types
rd_abort  in  N_RD  requester discards its outstanding read
rd_rdy  out  N_RD  one-cycle address accept
rd_data  out  LINE_W  broadcast read data
rd_valid  out  N_RD  one-hot read data valid
wr_req  in  N_WR  write request, held until wr_rdy
wr_addr  in  N_WR*ADDR_W  packed write addresses
wr_data  in  N_WR*LINE_W  packed write data
wr_type  in  N_WR*TYPE_W  packed write types
wr_strb  in  N_WR*STRB_W  packed write strobes
wr_rdy  out  N_WR  one-cycle write accept
m_r_req, m_r_addr, m_r_type  out  1/ADDR_W/TYPE_W  downstream read request
m_r_rdy  in  1  downstream read address accept
m_re_data, m_re_valid  in  LINE_W/1  downstream read data
m_w_req, m_w_addr, m_w_data, m_w_type, m_w_strb  out  1/ADDR_W/LINE_W/TYPE_W/STRB_W  downstream write request
m_w_rdy  in  1  downstream write accept (write complete)

Behaviour:
- Reset (asynchronous):
  - FSM goes to IDLE; all outputs 0.
  - Read round-robin pointer resets to 0; starvation counter resets to 0; drop flag cleared.
  - Reset mid-transaction abandons it with no completion signalled; the downstream port is reset on the same reset.
- States: IDLE, RD_ADDR, RD_DATA, WR.
- IDLE arbitration, evaluated every cycle; the grant is registered:
  - A write is chosen if any wr_req and (no rd_req or starve_cnt < MAX_WAIT). Fixed priority among writes: index 0 first.
  - Otherwise a read is chosen if any rd_req: round-robin starting at rr_ptr.
  - Grant registered -> RD_ADDR or WR next cycle. IDLE-to-downstream-request latency is 1 cycle.
- starve_cnt:
  - Increments on each write grant while any rd_req is high.
  - Clears on any read grant, or when no rd_req is high.
  - Saturates at MAX_WAIT.
- RD_ADDR:
  - m_r_req=1; m_r_addr/m_r_type muxed from the granted slice.
  - rd_rdy[g] = m_r_rdy, combinational, same cycle.
  - On m_r_rdy -> RD_DATA, and rr_ptr = g+1 mod N_RD.
- RD_DATA:
  - rd_valid[g] = m_re_valid & ~drop; rd_data = m_re_data, combinational.
  - On m_re_valid -> IDLE.
  - drop is set by rd_abort[g] in RD_ADDR after the accept, or in RD_DATA. Once set, the response is consumed and suppressed.
  - If rd_abort and m_re_valid arrive in the same cycle, the data is suppressed.
  - rd_abort in RD_ADDR before the accept has no effect; the requester must still hold rd_req.
- WR:
  - m_w_req=1 with the granted slice's fields.
  - wr_rdy[g] = m_w_rdy, combinational.
  - On m_w_rdy -> IDLE.
- Requests that drop without an accept are a protocol violation. The grant stays locked until the downstream handshake completes.
- No address-hazard checking. Requesters order dependent writes and reads themselves; the dcache flushes before it refills.

Optional Feature:
- SRAM_ARB_PERF_EN:
  - Defined: adds output ports perf_rd_grants (N_RD*32) and perf_wr_grants (N_WR*32), plus perf_stall (32). perf_stall counts cycles in which any request is pending in a state other than IDLE. All counters are free-running, wrap at 2^32, and reset to 0.
  - Undefined: these ports and their logic are absent. Arbitration behaviour is identical in both cases.

Decomposition:
- Shared package holds:
  - State enum (IDLE, RD_ADDR, RD_DATA, WR).
  - Requester index constants (RD_ICACHE=0, RD_DCACHE=1, RD_UNCACHED=2, WR_DCACHE=0, WR_UNCACHED=1).
  - SRAM bus field widths.
- One sub-module: rr_pick, a combinational round-robin picker. Inputs: request vector and pointer. Output: one-hot grant.

Test Plan:
- Only rd_req[0], addr 0x8000_0000; downstream m_r_rdy=1 after 2 cycles, m_re_valid 3 cycles later -> rd_rdy[0] pulses once, then rd_valid[0]=1 with data 0xA5..A5; return to IDLE.
- All three rd_req held constantly, zero-latency downstream -> grant order 0,1,2,0,1,2; no requester is granted twice in a row.
- wr_req[0] and rd_req[1] held constantly, MAX_WAIT=8 -> 8 write grants, then 1 read grant, then starve_cnt=0 and writes resume.
- rd_abort[2] asserted one cycle after rd_rdy[2] -> m_re_valid is consumed, rd_valid stays 0, and the next grant proceeds normally.
- reset asserted in RD_DATA -> outputs 0 immediately (asynchronous); after release, a pending rd_req[1] is granted from IDLE.
- wr_req[0] and wr_req[1] simultaneous -> wr_rdy[0] first, then wr_rdy[1]; m_w_data matches each slice.

Source files
------------

// File: rtl/sram_rr_arbiter_pkg.sv
// ============================================================================
// Module   : sram_rr_arbiter_pkg
// Purpose  : Shared state encoding, requester indices and SRAM bus widths.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package sram_rr_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_ADDR = 2'd1,
    RD_DATA = 2'd2,
    WR      = 2'd3
  } arb_state_t;

  localparam int RD_ICACHE   = 0;
  localparam int RD_DCACHE   = 1;
  localparam int RD_UNCACHED = 2;
  localparam int WR_DCACHE   = 0;
  localparam int WR_UNCACHED = 1;

  localparam int NUM_RD       = 3;
  localparam int NUM_WR       = 2;
  localparam int SRAM_ADDR_W  = 32;
  localparam int SRAM_LINE_W  = 256;
  localparam int SRAM_TYPE_W  = 6;
  localparam int SRAM_STRB_W  = 16;
  localparam int DEF_MAX_WAIT = 8;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/sram_rr_arbiter_if.sv
// ============================================================================
// Module   : sram_rr_arbiter_if
// Purpose  : Requester-side and downstream SRAM-port signals of the arbiter.
//            slave = arbiter view, master = requesters plus memory view.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface sram_rr_arbiter_if
  import sram_rr_arbiter_pkg::*;
#(
  parameter int N_RD   = NUM_RD,
  parameter int N_WR   = NUM_WR,
  parameter int ADDR_W = SRAM_ADDR_W,
  parameter int LINE_W = SRAM_LINE_W,
  parameter int TYPE_W = SRAM_TYPE_W,
  parameter int STRB_W = SRAM_STRB_W
) ();

  logic [N_RD-1:0]        rd_req;
  logic [N_RD*ADDR_W-1:0] rd_addr;
  logic [N_RD*TYPE_W-1:0] rd_type;
  logic [N_RD-1:0]        rd_abort;
  logic [N_RD-1:0]        rd_rdy;
  logic [LINE_W-1:0]      rd_data;
  logic [N_RD-1:0]        rd_valid;

  logic [N_WR-1:0]        wr_req;
  logic [N_WR*ADDR_W-1:0] wr_addr;
  logic [N_WR*LINE_W-1:0] wr_data;
  logic [N_WR*TYPE_W-1:0] wr_type;
  logic [N_WR*STRB_W-1:0] wr_strb;
  logic [N_WR-1:0]        wr_rdy;

  logic                   m_r_req;
  logic [ADDR_W-1:0]      m_r_addr;
  logic [TYPE_W-1:0]      m_r_type;
  logic                   m_r_rdy;
  logic [LINE_W-1:0]      m_re_data;
  logic                   m_re_valid;

  logic                   m_w_req;
  logic [ADDR_W-1:0]      m_w_addr;
  logic [LINE_W-1:0]      m_w_data;
  logic [TYPE_W-1:0]      m_w_type;
  logic [STRB_W-1:0]      m_w_strb;
  logic                   m_w_rdy;

  modport slave (
    input  rd_req, rd_addr, rd_type, rd_abort,
    output rd_rdy, rd_data, rd_valid,
    input  wr_req, wr_addr, wr_data, wr_type, wr_strb,
    output wr_rdy,
    output m_r_req, m_r_addr, m_r_type,
    input  m_r_rdy, m_re_data, m_re_valid,
    output m_w_req, m_w_addr, m_w_data, m_w_type, m_w_strb,
    input  m_w_rdy
  );

  modport master (
    output rd_req, rd_addr, rd_type, rd_abort,
    input  rd_rdy, rd_data, rd_valid,
    output wr_req, wr_addr, wr_data, wr_type, wr_strb,
    input  wr_rdy,
    input  m_r_req, m_r_addr, m_r_type,
    output m_r_rdy, m_re_data, m_re_valid,
    input  m_w_req, m_w_addr, m_w_data, m_w_type, m_w_strb,
    output m_w_rdy
  );

endinterface

`default_nettype wire

// File: rtl/sram_rr_arbiter_rr_pick.sv
// ============================================================================
// Module   : sram_rr_arbiter_rr_pick
// Purpose  : Combinational round-robin picker; searches upward from i_ptr.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sram_rr_arbiter_rr_pick #(
  parameter int N     = 3,
  parameter int PTR_W = (N > 1) ? $clog2(N) : 1
) (
  input  wire logic [N-1:0]     i_req,
  input  wire logic [PTR_W-1:0] i_ptr,
  output logic      [N-1:0]     o_gnt
);

  int   w_idx;
  logic w_found;

  always_comb begin
    o_gnt   = '0;
    w_found = 1'b0;
    w_idx   = 0;
    for (int i = 0; i < N; i++) begin
      w_idx = (int'(i_ptr) + i) % N;
      if (!w_found && i_req[w_idx]) begin
        o_gnt[w_idx] = 1'b1;
        w_found      = 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/sram_rr_arbiter.sv
// ============================================================================
// Module   : sram_rr_arbiter
// Purpose  : Shares one SRAM-style port between cache/uncached requesters;
//            writes first (bounded by read starvation), reads round-robin.
//            Optional grant/stall counters: define SRAM_ARB_PERF_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sram_rr_arbiter
  import sram_rr_arbiter_pkg::*;
#(
  parameter int N_RD     = NUM_RD,
  parameter int N_WR     = NUM_WR,
  parameter int ADDR_W   = SRAM_ADDR_W,
  parameter int LINE_W   = SRAM_LINE_W,
  parameter int TYPE_W   = SRAM_TYPE_W,
  parameter int STRB_W   = SRAM_STRB_W,
  parameter int MAX_WAIT = DEF_MAX_WAIT
) (
  input  wire logic        clk,
  input  wire logic        rst,
  sram_rr_arbiter_if.slave bus
`ifdef SRAM_ARB_PERF_EN
  ,
  output logic [N_RD*32-1:0] perf_rd_grants,
  output logic [N_WR*32-1:0] perf_wr_grants,
  output logic [31:0]        perf_stall
`endif
);

  localparam int c_rd_idx_w = idx_w(N_RD);
  localparam int c_wr_idx_w = idx_w(N_WR);
  localparam int c_cnt_w    = $clog2(MAX_WAIT + 1);
  localparam logic [c_cnt_w-1:0]    c_max_wait = c_cnt_w'(MAX_WAIT);
  localparam logic [c_rd_idx_w-1:0] c_rd_last  = c_rd_idx_w'(N_RD - 1);

  arb_state_t              r_state, w_state_nxt;
  logic [c_rd_idx_w-1:0]   r_rd_idx, r_rr_ptr, w_rd_pick_idx;
  logic [c_wr_idx_w-1:0]   r_wr_idx, w_wr_pick_idx;
  logic [N_RD-1:0]         w_rd_pick_oh;
  logic [c_cnt_w-1:0]      r_starve;
  logic                    r_drop;
  logic                    w_any_rd, w_any_wr, w_grant_wr, w_grant_rd;
  logic                    w_drop_now, w_rd_accept;

  assign w_any_rd    = |bus.rd_req;
  assign w_any_wr    = |bus.wr_req;
  assign w_grant_wr  = (r_state == IDLE) && w_any_wr && (!w_any_rd || (r_starve < c_max_wait));
  assign w_grant_rd  = (r_state == IDLE) && !w_grant_wr && w_any_rd;
  assign w_rd_accept = (r_state == RD_ADDR) && bus.m_r_rdy;
  // An abort in the data phase also kills data arriving in that same cycle.
  assign w_drop_now  = r_drop | bus.rd_abort[r_rd_idx];

  sram_rr_arbiter_rr_pick #(
    .N     (N_RD),
    .PTR_W (c_rd_idx_w)
  ) u_rr_pick (
    .i_req (bus.rd_req),
    .i_ptr (r_rr_ptr),
    .o_gnt (w_rd_pick_oh)
  );

  always_comb begin
    w_rd_pick_idx = '0;
    for (int i = 0; i < N_RD; i++) begin
      if (w_rd_pick_oh[i]) w_rd_pick_idx = c_rd_idx_w'(i);
    end
  end

  // Descending scan so the lowest requesting index wins.
  always_comb begin
    w_wr_pick_idx = '0;
    for (int i = N_WR - 1; i >= 0; i--) begin
      if (bus.wr_req[i]) w_wr_pick_idx = c_wr_idx_w'(i);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt  = r_state;
    bus.rd_rdy   = '0;
    bus.rd_valid = '0;
    bus.rd_data  = '0;
    bus.wr_rdy   = '0;
    bus.m_r_req  = 1'b0;
    bus.m_r_addr = '0;
    bus.m_r_type = '0;
    bus.m_w_req  = 1'b0;
    bus.m_w_addr = '0;
    bus.m_w_data = '0;
    bus.m_w_type = '0;
    bus.m_w_strb = '0;
    case (r_state)
      IDLE: begin
        if (w_grant_wr)      w_state_nxt = WR;
        else if (w_grant_rd) w_state_nxt = RD_ADDR;
      end
      RD_ADDR: begin
        bus.m_r_req          = 1'b1;
        bus.m_r_addr         = bus.rd_addr[r_rd_idx*ADDR_W +: ADDR_W];
        bus.m_r_type         = bus.rd_type[r_rd_idx*TYPE_W +: TYPE_W];
        bus.rd_rdy[r_rd_idx] = bus.m_r_rdy;
        if (bus.m_r_rdy) w_state_nxt = RD_DATA;
      end
      RD_DATA: begin
        bus.rd_data            = bus.m_re_data;
        bus.rd_valid[r_rd_idx] = bus.m_re_valid & ~w_drop_now;
        if (bus.m_re_valid) w_state_nxt = IDLE;
      end
      WR: begin
        bus.m_w_req          = 1'b1;
        bus.m_w_addr         = bus.wr_addr[r_wr_idx*ADDR_W +: ADDR_W];
        bus.m_w_data         = bus.wr_data[r_wr_idx*LINE_W +: LINE_W];
        bus.m_w_type         = bus.wr_type[r_wr_idx*TYPE_W +: TYPE_W];
        bus.m_w_strb         = bus.wr_strb[r_wr_idx*STRB_W +: STRB_W];
        bus.wr_rdy[r_wr_idx] = bus.m_w_rdy;
        if (bus.m_w_rdy) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_idx <= '0;
      r_wr_idx <= '0;
      r_rr_ptr <= '0;
      r_starve <= '0;
      r_drop   <= 1'b0;
    end else begin
      if (w_grant_wr) r_wr_idx <= w_wr_pick_idx;
      if (w_grant_rd) r_rd_idx <= w_rd_pick_idx;
      if (w_rd_accept) r_rr_ptr <= (r_rd_idx == c_rd_last) ? '0 : r_rd_idx + 1'b1;

      if (!w_any_rd || w_grant_rd)             r_starve <= '0;
      else if (w_grant_wr && (r_starve < c_max_wait)) r_starve <= r_starve + 1'b1;

      // Abort only counts once the address has been accepted.
      if (w_rd_accept)
        r_drop <= bus.rd_abort[r_rd_idx];
      else if (r_state == RD_DATA)
        r_drop <= bus.m_re_valid ? 1'b0 : w_drop_now;
    end
  end

`ifdef SRAM_ARB_PERF_EN
  logic [31:0] r_perf_stall;

  for (genvar gi = 0; gi < N_RD; gi++) begin : g_perf_rd
    logic [31:0] r_cnt;
    always_ff @(posedge clk or posedge rst) begin
      if (rst)                                r_cnt <= '0;
      else if (w_grant_rd && w_rd_pick_oh[gi]) r_cnt <= r_cnt + 32'd1;
    end
    assign perf_rd_grants[gi*32 +: 32] = r_cnt;
  end

  for (genvar gi = 0; gi < N_WR; gi++) begin : g_perf_wr
    logic [31:0] r_cnt;
    always_ff @(posedge clk or posedge rst) begin
      if (rst)                                                r_cnt <= '0;
      else if (w_grant_wr && (w_wr_pick_idx == c_wr_idx_w'(gi))) r_cnt <= r_cnt + 32'd1;
    end
    assign perf_wr_grants[gi*32 +: 32] = r_cnt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                             r_perf_stall <= '0;
    else if ((r_state != IDLE) && (w_any_rd || w_any_wr)) r_perf_stall <= r_perf_stall + 32'd1;
  end
  assign perf_stall = r_perf_stall;
`endif

endmodule

`default_nettype wire
